// File: rtl/mac_pkg.sv
// Shared types and default sizing for the MAC operand feeder.
package mac_pkg;

    localparam int DW      = 4;
    localparam int LEN_W   = 4;
    localparam int DEPTH   = 8;
    localparam int ACC_LAT = 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/mac_operand_fifo.sv
// First-word-fall-through synchronous FIFO holding packed a/b operand pairs.
module mac_operand_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign fill    = count;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: the storage array has no reset; count and pointers alone decide
    // which entries are valid, so clearing the data would only cost area.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_operand_feeder.sv
// Buffers operand pairs and streams one fixed-length vector per start into the MAC,
// framing it with a clear pulse and a done pulse once the accumulator has settled.
module mac_operand_feeder
    import mac_pkg::*;
#(
    parameter int DW      = mac_pkg::DW,
    parameter int DEPTH   = mac_pkg::DEPTH,
    parameter int LEN_W   = mac_pkg::LEN_W,
    parameter int ACC_LAT = mac_pkg::ACC_LAT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_a,
    input  logic [DW-1:0]            in_b,
    input  logic                     start,
    input  logic [LEN_W-1:0]         vec_len,
    output logic [DW-1:0]            a,
    output logic [DW-1:0]            b,
    output logic                     mac_en,
    output logic                     mac_clr,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int CW = (ACC_LAT > 0) ? $clog2(ACC_LAT + 1) : 1;

    state_t            state;
    logic [LEN_W-1:0]  remaining;
    logic [CW-1:0]     drain_cnt;
    logic              live;
    logic              full;
    logic              empty;
    logic              pop;
    logic [2*DW-1:0]   head;

    // live holds in_ready low until the first clock after reset release.
    assign in_ready = live && !full;
    assign busy     = (state != IDLE);
    assign pop      = ((state == CLEAR) || (state == FEED)) && !empty;

    mac_operand_fifo #(
        .W     (2 * DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .din   ({in_a, in_b}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .fill  (fill)
    );

    // NOTE: every register below uses non-blocking assignment, so the pulse
    // defaults at the top are safely overridden later in the same block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= '0;
            drain_cnt <= '0;
            live      <= 1'b0;
            a         <= '0;
            b         <= '0;
            mac_en    <= 1'b0;
            mac_clr   <= 1'b0;
            done      <= 1'b0;
        end else begin
            live    <= 1'b1;
            mac_en  <= 1'b0;
            mac_clr <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (vec_len != '0) begin
                            remaining <= vec_len;
                            mac_clr   <= 1'b1;
                            state     <= CLEAR;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                // The clear cycle may already pop, so the first enable
                // directly follows the clear pulse.
                CLEAR, FEED: begin
                    state <= FEED;
                    if (pop) begin
                        a         <= head[2*DW-1:DW];
                        b         <= head[DW-1:0];
                        mac_en    <= 1'b1;
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            drain_cnt <= CW'(ACC_LAT);
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt - CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder with a behavioural MAC accumulator downstream.
module tb_mac_operand_feeder;

    localparam int DW      = 4;
    localparam int DEPTH   = 8;
    localparam int LEN_W   = 4;
    localparam int ACC_LAT = 1;
    localparam int FW      = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DW-1:0]    in_a = '0;
    logic [DW-1:0]    in_b = '0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] vec_len = '0;
    logic [DW-1:0]    a;
    logic [DW-1:0]    b;
    logic             mac_en;
    logic             mac_clr;
    logic             busy;
    logic             done;
    logic [FW-1:0]    fill;

    int checks = 0;
    int errors = 0;

    // Downstream MAC model and event bookkeeping
    int acc = 0;
    int cyc = 0;
    int en_cnt = 0;
    int clr_cnt = 0;
    int done_cnt = 0;
    int viol_cnt = 0;
    int max_fill = 0;
    int clr_cyc = 0;
    int first_en_cyc = 0;
    int last_en_cyc = 0;
    int done_cyc = 0;
    bit clr_pending = 1'b0;

    mac_operand_feeder #(
        .DW      (DW),
        .DEPTH   (DEPTH),
        .LEN_W   (LEN_W),
        .ACC_LAT (ACC_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .start    (start),
        .vec_len  (vec_len),
        .a        (a),
        .b        (b),
        .mac_en   (mac_en),
        .mac_clr  (mac_clr),
        .busy     (busy),
        .done     (done),
        .fill     (fill)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            if (mac_clr) begin
                acc         <= 0;
                clr_cnt     <= clr_cnt + 1;
                clr_cyc     <= cyc;
                clr_pending <= 1'b1;
            end else if (mac_en) begin
                acc <= acc + int'(a) * int'(b);
            end
            if (mac_en) begin
                en_cnt      <= en_cnt + 1;
                last_en_cyc <= cyc;
                if (clr_pending) begin
                    first_en_cyc <= cyc;
                    clr_pending  <= 1'b0;
                end
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if ((mac_clr && mac_en) || (done && mac_en)) begin
                viol_cnt <= viol_cnt + 1;
            end
            if (int'(fill) > max_fill) begin
                max_fill <= int'(fill);
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int pa, input int pb);
        int n = 0;
        in_valid = 1'b1;
        in_a     = DW'(pa);
        in_b     = DW'(pb);
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("push_ready_timeout", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic kick(input int len);
        start   = 1'b1;
        vec_len = LEN_W'(len);
        tick();
        start   = 1'b0;
        vec_len = '0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 80) begin
            tick();
            n++;
        end
        check({tag, "_done_timeout"}, int'(done), 1);
    endtask

    int en0, clr0, done0;

    initial begin
        // 1: reset held for 3 cycles
        #1;
        repeat (3) tick();
        check("rst_outputs", int'({a, b, mac_en, mac_clr, busy, done}), 0);
        check("rst_fill", int'(fill), 0);
        check("rst_in_ready", int'(in_ready), 0);
        rst = 1'b1;
        #1;
        check("release_in_ready_low", int'(in_ready), 0);
        tick();
        check("release_in_ready_high", int'(in_ready), 1);

        // 2: preloaded 3-pair vector
        push(2, 5);
        push(3, 4);
        push(1, 7);
        check("t2_fill", int'(fill), 3);
        en0 = en_cnt; clr0 = clr_cnt; done0 = done_cnt;
        kick(3);
        check("t2_clr_first", int'(mac_clr), 1);
        check("t2_busy", int'(busy), 1);
        wait_done("t2");
        check("t2_y", acc, 29);
        tick();
        check("t2_en_count", en_cnt - en0, 3);
        check("t2_clr_count", clr_cnt - clr0, 1);
        check("t2_done_count", done_cnt - done0, 1);
        check("t2_clr_to_en", first_en_cyc - clr_cyc, 1);
        check("t2_en_span", last_en_cyc - first_en_cyc, 2);
        check("t2_en_to_done", done_cyc - last_en_cyc, 1 + ACC_LAT);
        check("t2_idle", int'({busy, done}), 0);

        // 3: start on empty FIFO, stall between pairs
        en0 = en_cnt; done0 = done_cnt;
        kick(2);
        push(6, 3);
        repeat (4) tick();
        check("t3_stall_en", int'(mac_en), 0);
        check("t3_hold_a", int'(a), 6);
        check("t3_hold_b", int'(b), 3);
        check("t3_stall_busy", int'(busy), 1);
        push(5, 2);
        wait_done("t3");
        check("t3_y", acc, 28);
        tick();
        check("t3_en_count", en_cnt - en0, 2);
        check("t3_done_count", done_cnt - done0, 1);
        check("t3_last_a", int'(a), 5);

        // 4: overfill by one
        en0 = en_cnt;
        for (int i = 1; i <= 8; i++) push(i, 1);
        check("t4_full_ready", int'(in_ready), 0);
        check("t4_full_fill", int'(fill), 8);
        in_valid = 1'b1;
        in_a     = 4'd9;
        in_b     = 4'd1;
        kick(9);
        begin
            int n = 0;
            while (!in_ready && n < 20) begin
                tick();
                n++;
            end
            check("t4_ninth_accepted", int'(in_ready), 1);
            tick();
            in_valid = 1'b0;
        end
        wait_done("t4");
        check("t4_y", acc, 45);
        tick();
        check("t4_en_count", en_cnt - en0, 9);
        check("t4_max_fill", max_fill, 8);
        check("t4_empty", int'(fill), 0);

        // 5: zero-length vector
        push(4, 4);
        en0 = en_cnt; clr0 = clr_cnt; done0 = done_cnt;
        kick(0);
        check("t5_done_now", int'(done), 1);
        check("t5_no_clr_en", int'({mac_clr, mac_en}), 0);
        tick();
        check("t5_done_once", int'(done), 0);
        check("t5_idle", int'(busy), 0);
        check("t5_fill", int'(fill), 1);
        check("t5_counts", (en_cnt - en0) + (clr_cnt - clr0), 0);
        check("t5_done_count", done_cnt - done0, 1);
        check("t5_acc_kept", acc, 45);

        // 6: reset during FEED of a 5-pair vector
        push(1, 2);
        push(2, 2);
        en0 = en_cnt; done0 = done_cnt;
        kick(5);
        repeat (6) tick();
        check("t6_mid_busy", int'(busy), 1);
        check("t6_mid_en_seen", en_cnt - en0, 3);
        rst = 1'b0;
        #1;
        check("t6_rst_outputs", int'({a, b, mac_en, mac_clr, busy, done}), 0);
        check("t6_rst_fill", int'(fill), 0);
        check("t6_rst_ready", int'(in_ready), 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("t6_no_done", done_cnt - done0, 0);
        push(3, 3);
        push(2, 2);
        done0 = done_cnt;
        kick(2);
        check("t6_fresh_clr", int'(mac_clr), 1);
        wait_done("t6");
        check("t6_y", acc, 13);
        tick();
        check("t6_done_count", done_cnt - done0, 1);
        check("exclusive_pulses", viol_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
